// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, addresses the combinational instruction
// memory and captures the returned word into the IF/ID register. A small
// IDLE/RUN/FAULT state machine handles start-up, stalls, branch/jump
// redirects and running off the end of the populated memory.
module instr_fetch_unit #(
  parameter int ADDR_W    = 32,
  parameter int MEM_DEPTH = 100,
  parameter int RESET_PC  = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_instr,
  output logic [31:0]       if_id_instr,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic              if_id_valid,
  output logic              fetch_fault,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
  localparam logic [ADDR_W-1:0] PC_INIT = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] pc;

  // The range check is done on the current PC before any increment, so the
  // PC can never wrap past the top of the address space while running.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return (a < DEPTH_A);
  endfunction

  // Memory is read combinationally from the live PC in every state.
  assign imem_addr = pc;

  // Fetch state machine: PC, IF/ID register, fault flag and delivery counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pc          <= PC_INIT;
      if_id_instr <= 32'd0;
      if_id_pc    <= '0;
      if_id_valid <= 1'b0;
      fetch_fault <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if_id_valid <= 1'b0;
          if (redirect) begin
            pc <= redirect_pc;
          end
          if (start) begin
            state <= RUN;
          end
        end

        RUN: begin
          if (redirect) begin
            // Squash whatever is in flight and insert a bubble.
            pc          <= redirect_pc;
            if_id_valid <= 1'b0;
            if_id_instr <= 32'd0;
          end else if (stall) begin
            // Hold everything.
            pc <= pc;
          end else if (in_range(pc)) begin
            if_id_instr <= imem_instr;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            pc          <= pc + PC_ONE;
            fetch_count <= fetch_count + 32'd1;
          end else begin
            // PC ran off the populated memory: park here until redirected.
            if_id_valid <= 1'b0;
            fetch_fault <= 1'b1;
            state       <= FAULT;
          end
        end

        FAULT: begin
          if_id_valid <= 1'b0;
          if (redirect) begin
            pc          <= redirect_pc;
            fetch_fault <= 1'b0;
            state       <= RUN;
          end
        end

        default: begin
          state       <= IDLE;
          if_id_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit. Each fetch the stimulus expects is
// queued; a negedge monitor pops and compares every newly delivered IF/ID
// word. Non-delivery conditions (reset, bubbles, stalls, faults) are checked
// directly from the stimulus thread.
module tb_instr_fetch_unit;

  localparam int ADDR_W    = 32;
  localparam int MEM_DEPTH = 100;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              stall = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_instr;
  logic [31:0]       if_id_instr;
  logic [ADDR_W-1:0] if_id_pc;
  logic              if_id_valid;
  logic              fetch_fault;
  logic [31:0]       fetch_count;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          failures = 0;
  logic [31:0] m_pc = 32'd0;
  logic [31:0] m_cnt = 32'd0;
  logic        stall_at_edge = 1'b0;

  instr_fetch_unit #(
    .ADDR_W   (ADDR_W),
    .MEM_DEPTH(MEM_DEPTH),
    .RESET_PC (0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .imem_addr  (imem_addr),
    .imem_instr (imem_instr),
    .if_id_instr(if_id_instr),
    .if_id_pc   (if_id_pc),
    .if_id_valid(if_id_valid),
    .fetch_fault(fetch_fault),
    .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a distinct word per address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return 32'hA500_0F0F ^ (a * 32'h0001_0001);
  endfunction

  assign imem_instr = word(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Queue one expected delivery per fetch edge, from the bench's own PC/count.
  task automatic fetch_n(input int n);
    for (int i = 0; i < n; i++) begin
      sbq.push_back('{instr: word(m_pc), pc: m_pc, cnt: m_cnt + 32'd1});
      m_pc  = m_pc + 32'd1;
      m_cnt = m_cnt + 32'd1;
      cyc();
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_valid"}, {31'd0, if_id_valid}, 32'd0);
    chk({tag, "_instr"}, if_id_instr, 32'd0);
    chk({tag, "_pc"},    if_id_pc, 32'd0);
    chk({tag, "_fault"}, {31'd0, fetch_fault}, 32'd0);
    chk({tag, "_count"}, fetch_count, 32'd0);
    chk({tag, "_addr"},  imem_addr, 32'd0);
  endtask

  // Remember whether the most recent edge was a stall edge (no new delivery).
  always @(posedge clk) stall_at_edge = stall;

  // Monitor: every new valid IF/ID word must match the head of the queue.
  always @(negedge clk) begin
    if (rst_n && if_id_valid && !stall_at_edge) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_delivery actual_pc=%h required=none", if_id_pc);
      end else begin
        exp_t e;
        e = sbq.pop_front();
        chk("sb_instr", if_id_instr, e.instr);
        chk("sb_pc",    if_id_pc,    e.pc);
        chk("sb_count", fetch_count, e.cnt);
      end
    end
  end

  initial begin
    // Reset state
    @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // No fetch while idle
    cyc();
    cyc();
    chk("idle_valid", {31'd0, if_id_valid}, 32'd0);
    chk("idle_addr", imem_addr, 32'd0);

    // Straight-line fetch of words 0..5
    start = 1'b1;
    cyc();
    start = 1'b0;
    chk("run_first_addr", imem_addr, 32'd0);
    fetch_n(6);
    chk("count_after6", fetch_count, 32'd6);
    chk("last_pc_after6", if_id_pc, 32'd5);

    // Two-cycle stall holds PC, IF/ID and count
    stall = 1'b1;
    cyc();
    cyc();
    chk("stall_if_pc", if_id_pc, 32'd5);
    chk("stall_addr", imem_addr, 32'd6);
    chk("stall_count", fetch_count, 32'd6);
    chk("stall_valid", {31'd0, if_id_valid}, 32'd1);
    stall = 1'b0;
    fetch_n(1);

    // Redirect: bubble then target
    redirect = 1'b1;
    redirect_pc = 32'd5;
    cyc();
    redirect = 1'b0;
    chk("bubble_valid", {31'd0, if_id_valid}, 32'd0);
    chk("bubble_instr", if_id_instr, 32'd0);
    chk("redir_addr", imem_addr, 32'd5);
    m_pc = 32'd5;
    fetch_n(1);

    // Stall and redirect together: redirect wins
    stall = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'd7;
    cyc();
    stall = 1'b0;
    redirect = 1'b0;
    chk("sr_valid", {31'd0, if_id_valid}, 32'd0);
    chk("sr_addr", imem_addr, 32'd7);
    m_pc = 32'd7;
    fetch_n(1);

    // Run off the end of memory
    redirect = 1'b1;
    redirect_pc = 32'd98;
    cyc();
    redirect = 1'b0;
    m_pc = 32'd98;
    fetch_n(2);
    chk("edge_pc99", if_id_pc, 32'd99);
    cyc();
    chk("fault_set", {31'd0, fetch_fault}, 32'd1);
    chk("fault_valid", {31'd0, if_id_valid}, 32'd0);
    chk("fault_addr", imem_addr, 32'd100);
    chk("fault_count", fetch_count, m_cnt);
    start = 1'b1;
    stall = 1'b1;
    cyc();
    start = 1'b0;
    stall = 1'b0;
    chk("fault_held", {31'd0, fetch_fault}, 32'd1);
    chk("fault_held_addr", imem_addr, 32'd100);
    redirect = 1'b1;
    redirect_pc = 32'd0;
    cyc();
    redirect = 1'b0;
    chk("fault_clear", {31'd0, fetch_fault}, 32'd0);
    chk("fault_clear_addr", imem_addr, 32'd0);
    m_pc = 32'd0;
    fetch_n(2);

    // Redirect outside memory is accepted, faults on the next fetch
    redirect = 1'b1;
    redirect_pc = 32'd150;
    cyc();
    redirect = 1'b0;
    chk("oor_addr", imem_addr, 32'd150);
    chk("oor_nofault", {31'd0, fetch_fault}, 32'd0);
    cyc();
    chk("oor_fault", {31'd0, fetch_fault}, 32'd1);
    chk("oor_fault_addr", imem_addr, 32'd150);
    redirect = 1'b1;
    redirect_pc = 32'd2;
    cyc();
    redirect = 1'b0;
    m_pc = 32'd2;
    fetch_n(2);
    chk("pre_reset_addr", imem_addr, 32'd4);

    // Asynchronous reset mid-run, between clock edges
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");
    cyc();
    rst_n = 1'b1;
    m_pc = 32'd0;
    m_cnt = 32'd0;
    cyc();
    cyc();
    chk("post_reset_idle_valid", {31'd0, if_id_valid}, 32'd0);
    chk("post_reset_idle_addr", imem_addr, 32'd0);
    chk("post_reset_idle_count", fetch_count, 32'd0);

    // Start together with redirect from IDLE
    start = 1'b1;
    redirect = 1'b1;
    redirect_pc = 32'd10;
    cyc();
    start = 1'b0;
    redirect = 1'b0;
    chk("idle_sr_addr", imem_addr, 32'd10);
    chk("idle_sr_valid", {31'd0, if_id_valid}, 32'd0);
    m_pc = 32'd10;
    fetch_n(3);
    chk("restart_count", fetch_count, 32'd3);

    @(negedge clk);
    #1;
    chk("sb_drained", sbq.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
